keypad_scan: RTL and testbench

Front-panel 4x4 matrix keypad scanner, the input-side counterpart of the multiplexed seven-segment display driver.
- Drives one column low at a time and samples the four row inputs.
- Debounces whole scan frames.
- Reports each new key press as a 4-bit code through a one-entry valid/ready holding register to the console/debug logic.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_sync.sv | 30 +++
 rtl/keypad_scan.sv | 128 ++++++++++++
 tb/tb_keypad_scan.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// ------------------------------------------------------------------
// keypad_pkg: shared keypad geometry and lowest-set-bit helper. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1111;

  function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [15:0] v);
    lowest_set = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = i[KEY_CODE_W-1:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_sync.sv
// ------------------------------------------------------------------
// keypad_sync: 2-flop synchroniser for the active-low row inputs. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module keypad_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] d,
  output logic [NUM_ROWS-1:0] q
);

  logic [NUM_ROWS-1:0] meta;

  // Idle (all high) reset keeps the scanner from seeing phantom presses
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= COL_IDLE;
      q    <= COL_IDLE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ------------------------------------------------------------------
// keypad_scan: 4x4 keypad scanner, frame debounce, press-event register.
// Optional release events with KEYPAD_RELEASE_EN. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module keypad_scan
  import keypad_pkg::*;
#(
  parameter int DIV_BITS = 11,
  parameter int DEBOUNCE = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_ROWS-1:0]       rows,
  output logic [NUM_COLS-1:0]       cols,
  output logic [15:0]               keys,
  output logic                      key_valid,
  output logic [KEY_CODE_W-1:0]     key_code,
  input  logic                      key_ready,
  output logic                      overflow
`ifdef KEYPAD_RELEASE_EN
  ,output logic                     key_release
`endif
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic [DIV_BITS-1:0]   divider;
  logic                  tick;
  logic [1:0]            col;
  logic [NUM_ROWS-1:0]   sync_rows;
  logic [15:0]           raw;
  logic [15:0]           frame;
  logic [15:0]           prev;
  logic [3:0]            match_cnt;
  logic [15:0]           keys_old;
  logic [15:0]           press_bits;
  logic                  ev;
  logic [KEY_CODE_W-1:0] ev_code;

  keypad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (sync_rows)
  );

  assign tick = &divider;
  assign cols = ~(4'b0001 << col);

  // raw with the current column's nibble replaced by the live sample
  always_comb begin
    frame = raw;
    frame[col*NUM_ROWS +: NUM_ROWS] = ~sync_rows;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      divider   <= '0;
      col       <= 2'd0;
      raw       <= '0;
      prev      <= '0;
      match_cnt <= '0;
      keys      <= '0;
    end else begin
      divider <= divider + 1'b1;
      if (tick) begin
        raw <= frame;
        col <= col + 2'd1;
        if (col == 2'd3) begin
          if (frame != prev) begin
            prev      <= frame;
            match_cnt <= '0;
          end else if (match_cnt < DEB) begin
            match_cnt <= match_cnt + 4'd1;
            if (match_cnt + 4'd1 == DEB) keys <= prev;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) keys_old <= '0;
    else        keys_old <= keys;
  end

  assign press_bits = keys & ~keys_old;

`ifdef KEYPAD_RELEASE_EN
  logic [15:0] rel_bits;
  logic        ev_rel;

  assign rel_bits = keys_old & ~keys;
  assign ev_rel   = ~|press_bits;
  assign ev       = (|press_bits) || (|rel_bits);
  assign ev_code  = ev_rel ? lowest_set(rel_bits) : lowest_set(press_bits);
`else
  assign ev      = |press_bits;
  assign ev_code = lowest_set(press_bits);
`endif

  // One-entry holding register; a busy slot drops new events and flags it
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_valid   <= 1'b0;
      key_code    <= '0;
      overflow    <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
      key_release <= 1'b0;
`endif
    end else if (!ev) begin
      if (key_valid && key_ready) key_valid <= 1'b0;
    end else if (!key_valid || key_ready) begin
      key_valid   <= 1'b1;
      key_code    <= ev_code;
`ifdef KEYPAD_RELEASE_EN
      key_release <= ev_rel;
`endif
    end else begin
      overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ------------------------------------------------------------------
// tb_keypad_scan: vector table plus directed sequences, event scoreboard. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_keypad_scan;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] keys;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        overflow;
`ifdef KEYPAD_RELEASE_EN
  logic        key_release;
`endif

  logic [15:0] pressed;
  logic [3:0]  phase;
  int          checks;
  int          errors;

  typedef struct {
    logic [3:0] code;
    logic       rel;
  } ev_t;

  typedef struct {
    logic [15:0] press;
    logic [3:0]  code;
    logic        has_ev;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[6];
  logic [3:0] colseq[4];

  keypad_scan #(.DIV_BITS(2), .DEBOUNCE(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .rows        (rows),
    .cols        (cols),
    .keys        (keys),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .overflow    (overflow)
`ifdef KEYPAD_RELEASE_EN
    ,.key_release(key_release)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to a low-driven column
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !cols[c]) rows[r] = 1'b0;
  end

  // Position within a 16-cycle scan frame, counted from reset release
  always @(posedge clk) begin
    if (!reset) phase <= 4'd0;
    else        phase <= phase + 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic goto_frame_start();
    int w;
    w = 0;
    while (phase != 4'd0 && w < 32) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic accept(input string name);
    ev_t e;
    int  w;
    w = 0;
    while (!key_valid && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (!key_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got key_valid 0 expected 1", name);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected: got event code %0h expected none", name, key_code);
    end else begin
      e = sb.pop_front();
      chk({name, "_code"}, 32'(key_code), 32'(e.code));
`ifdef KEYPAD_RELEASE_EN
      chk({name, "_rel"}, 32'(key_release), 32'(e.rel));
`endif
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      chk({name, "_drop"}, 32'(key_valid), 32'd0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    pressed   = 16'h0;
    key_ready = 1'b0;
    reset     = 1'b0;

    colseq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    vecs[0] = '{16'h0200, 4'h9, 1'b1};
    vecs[1] = '{16'h1008, 4'h3, 1'b1};
    vecs[2] = '{16'h0001, 4'h0, 1'b1};
    vecs[3] = '{16'h8000, 4'hF, 1'b1};
    vecs[4] = '{16'h0000, 4'h0, 1'b0};
    vecs[5] = '{16'h00F0, 4'h4, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_keys", 32'(keys), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_cols", 32'(cols), 32'hE);
`ifdef KEYPAD_RELEASE_EN
    chk("rst_rel", 32'(key_release), 32'h0);
`endif
    reset = 1'b1;

    // Column scan sequence, 4 cycles per column
    for (int k = 0; k < 32; k++) begin
      chk("scan_cols", 32'(cols), 32'(colseq[(k/4)%4]));
      @(negedge clk);
    end
    chk("scan_keys", 32'(keys), 32'h0);
    chk("scan_valid", 32'(key_valid), 32'h0);

    // Table: press, debounce timing, event, release
    for (int i = 0; i < 6; i++) begin
      goto_frame_start();
      pressed = vecs[i].press;
      if (vecs[i].has_ev) sb.push_back('{vecs[i].code, 1'b0});
      run_frames(2);
      chk("vec_early_keys", 32'(keys), 32'h0);
      run_frames(1);
      chk("vec_keys", 32'(keys), 32'(vecs[i].press));
      chk("vec_valid_lat", 32'(key_valid), 32'h0);
      @(negedge clk);
      chk("vec_valid", 32'(key_valid), 32'(vecs[i].has_ev));
      if (vecs[i].has_ev) accept("vec");
      goto_frame_start();
      pressed = 16'h0;
`ifdef KEYPAD_RELEASE_EN
      if (vecs[i].has_ev) sb.push_back('{vecs[i].code, 1'b1});
`endif
      run_frames(3);
      chk("vec_rel_keys", 32'(keys), 32'h0);
      @(negedge clk);
`ifdef KEYPAD_RELEASE_EN
      if (vecs[i].has_ev) accept("vec_rel");
      else chk("vec_rel_valid", 32'(key_valid), 32'h0);
`else
      chk("vec_rel_valid", 32'(key_valid), 32'h0);
`endif
    end

    // Bounce: key 5 toggles for five frames, then stays pressed
    goto_frame_start();
    for (int f = 0; f < 5; f++) begin
      pressed = (f % 2 == 0) ? 16'h0020 : 16'h0000;
      run_frames(1);
      chk("bounce_keys", 32'(keys), 32'h0);
      chk("bounce_valid", 32'(key_valid), 32'h0);
    end
    sb.push_back('{4'h5, 1'b0});
    run_frames(1);
    chk("bounce_hold_keys", 32'(keys), 32'h0);
    run_frames(1);
    chk("bounce_settled", 32'(keys), 32'h0020);
    accept("bounce");
    goto_frame_start();
    pressed = 16'h0;
`ifdef KEYPAD_RELEASE_EN
    sb.push_back('{4'h5, 1'b1});
    run_frames(3);
    accept("bounce_rel");
`else
    run_frames(4);
    chk("bounce_rel_valid", 32'(key_valid), 32'h0);
`endif

    // Overflow: consumer stalls while more events arrive
    goto_frame_start();
    chk("ovf_pre", 32'(overflow), 32'h0);
    pressed = 16'h0020;
    sb.push_back('{4'h5, 1'b0});
    run_frames(3);
    @(negedge clk);
    chk("ovf_first_valid", 32'(key_valid), 32'h1);
    goto_frame_start();
    pressed = 16'h0;
    run_frames(3);
    chk("ovf_rel_keys", 32'(keys), 32'h0);
`ifndef KEYPAD_RELEASE_EN
    @(negedge clk);
    chk("ovf_rel_no_ovf", 32'(overflow), 32'h0);
`endif
    goto_frame_start();
    pressed = 16'h0080;
    run_frames(3);
    chk("ovf_keys7", 32'(keys), 32'h0080);
    repeat (2) @(negedge clk);
    chk("ovf_code_held", 32'(key_code), 32'h5);
    chk("ovf_valid_held", 32'(key_valid), 32'h1);
    chk("ovf_flag", 32'(overflow), 32'h1);
    accept("ovf");
    chk("ovf_sticky", 32'(overflow), 32'h1);
    goto_frame_start();
    pressed = 16'h0;
`ifdef KEYPAD_RELEASE_EN
    sb.push_back('{4'h7, 1'b1});
    run_frames(3);
    accept("ovf_rel7");
`else
    run_frames(4);
    chk("ovf_rel7_valid", 32'(key_valid), 32'h0);
`endif
    chk("ovf_sticky2", 32'(overflow), 32'h1);

    // Reset mid-frame with a pending key 0 event
    goto_frame_start();
    pressed = 16'h0001;
    sb.push_back('{4'h0, 1'b0});
    run_frames(3);
    @(negedge clk);
    chk("mid_valid", 32'(key_valid), 32'h1);
    chk("mid_code", 32'(key_code), 32'h0);
    repeat (4) @(negedge clk);
    reset   = 1'b0;
    pressed = 16'h0;
    @(negedge clk);
    chk("mid_rst_keys", 32'(keys), 32'h0);
    chk("mid_rst_valid", 32'(key_valid), 32'h0);
    chk("mid_rst_cols", 32'(cols), 32'hE);
    chk("mid_rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b1;
    sb.delete();
    run_frames(4);
    chk("post_rst_valid", 32'(key_valid), 32'h0);
    chk("post_rst_keys", 32'(keys), 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
